gate_checker: RTL and testbench

GATE_CHECKER -- requirements
Module: gate_checker

---
 rtl/gate_checker.sv | 146 ++++++++++++++
 tb/tb_gate_checker.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/gate_checker.sv
// ============================================================================
// gate_checker : online checker for a 2-input logic gate against a latched op.
// Optional first-failure logging is built when GATE_CHECKER_FAIL_LOG_EN is defined.
// Revision 1.0 - initial release
// ============================================================================
`default_nettype none

module gate_checker #(
    parameter int NUM_VEC = 4,
    parameter int CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [2:0]       op,
    input  logic             in_valid,
    input  logic             in_a,
    input  logic             in_b,
    input  logic             in_y,
    output logic             in_ready,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [CNT_W-1:0] vec_cnt,
    output logic [CNT_W-1:0] err_cnt,
    output logic [3:0]       cov,
    output logic [2:0]       first_fail,
    output logic             first_fail_vld
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] c_last_vec = CNT_W'(NUM_VEC);
    localparam logic [CNT_W-1:0] c_err_max  = '1;

    state_t           r_state;
    logic [2:0]       r_op;
    logic [CNT_W-1:0] r_vec_cnt;
    logic [CNT_W-1:0] r_err_cnt;
    logic [3:0]       r_cov;

    logic             w_accept;
    logic             w_start_run;
    logic             w_expected;
    logic             w_mismatch;
    logic [CNT_W-1:0] w_vec_next;

    assign w_accept    = in_valid && (r_state == S_RUN);
    assign w_start_run = start && !abort && (r_state != S_RUN);
    assign w_vec_next  = r_vec_cnt + 1'b1;

    // Reserved ops have no defined truth table, so every accepted vector fails.
    always_comb begin
        w_expected = 1'b0;
        w_mismatch = 1'b1;
        case (r_op)
            3'd0: begin w_expected =   in_a & in_b;  w_mismatch = (in_y != w_expected); end
            3'd1: begin w_expected =   in_a | in_b;  w_mismatch = (in_y != w_expected); end
            3'd2: begin w_expected =   in_a ^ in_b;  w_mismatch = (in_y != w_expected); end
            3'd3: begin w_expected = ~(in_a & in_b); w_mismatch = (in_y != w_expected); end
            3'd4: begin w_expected = ~(in_a | in_b); w_mismatch = (in_y != w_expected); end
            3'd5: begin w_expected = ~(in_a ^ in_b); w_mismatch = (in_y != w_expected); end
            default: begin w_expected = 1'b0; w_mismatch = 1'b1; end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_op      <= 3'd0;
            r_vec_cnt <= '0;
            r_err_cnt <= '0;
            r_cov     <= 4'h0;
        end else if (abort) begin
            r_state   <= S_IDLE;
            r_op      <= 3'd0;
            r_vec_cnt <= '0;
            r_err_cnt <= '0;
            r_cov     <= 4'h0;
        end else if (w_start_run) begin
            r_state   <= S_RUN;
            r_op      <= op;
            r_vec_cnt <= '0;
            r_err_cnt <= '0;
            r_cov     <= 4'h0;
        end else begin
            case (r_state)
                S_RUN: begin
                    if (w_accept) begin
                        r_vec_cnt <= w_vec_next;
                        r_cov[{in_a, in_b}] <= 1'b1;
                        if (w_mismatch && (r_err_cnt != c_err_max)) begin
                            r_err_cnt <= r_err_cnt + 1'b1;
                        end
                        if (w_vec_next == c_last_vec) begin
                            r_state <= S_DONE;
                        end
                    end
                end
                S_IDLE:  r_state <= S_IDLE;
                S_DONE:  r_state <= S_DONE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign in_ready = (r_state == S_RUN);
    assign busy     = (r_state == S_RUN);
    assign done     = (r_state == S_DONE);
    assign pass     = (r_state == S_DONE) && (r_err_cnt == '0) && (r_cov == 4'hF);
    assign vec_cnt  = r_vec_cnt;
    assign err_cnt  = r_err_cnt;
    assign cov      = r_cov;

`ifdef GATE_CHECKER_FAIL_LOG_EN
    logic [2:0] r_first_fail;
    logic       r_first_fail_vld;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_first_fail     <= 3'b000;
            r_first_fail_vld <= 1'b0;
        end else if (abort || w_start_run) begin
            r_first_fail     <= 3'b000;
            r_first_fail_vld <= 1'b0;
        end else if (w_accept && w_mismatch && !r_first_fail_vld) begin
            r_first_fail     <= {in_a, in_b, in_y};
            r_first_fail_vld <= 1'b1;
        end
    end

    assign first_fail     = r_first_fail;
    assign first_fail_vld = r_first_fail_vld;
`else
    assign first_fail     = 3'b000;
    assign first_fail_vld = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_gate_checker.sv
// ============================================================================
// tb_gate_checker : directed self-checking bench for gate_checker.
// Revision 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_gate_checker;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       start2 = 1'b0;
    logic       abort = 1'b0;
    logic [2:0] op = 3'd0;
    logic       in_valid = 1'b0;
    logic       in_a = 1'b0;
    logic       in_b = 1'b0;
    logic       in_y = 1'b0;

    logic       in_ready, busy, done, pass, first_fail_vld;
    logic [7:0] vec_cnt, err_cnt;
    logic [3:0] cov;
    logic [2:0] first_fail;

    logic       in_ready2, busy2, done2, pass2, first_fail_vld2;
    logic [7:0] vec_cnt2, err_cnt2;
    logic [3:0] cov2;
    logic [2:0] first_fail2;

    int n_total = 0;
    int n_bad   = 0;

    logic [2:0] exp_ff;
    logic       exp_ff_vld;

    always #5 clk = ~clk;

    gate_checker #(.NUM_VEC(4), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .op(op),
        .in_valid(in_valid), .in_a(in_a), .in_b(in_b), .in_y(in_y),
        .in_ready(in_ready), .busy(busy), .done(done), .pass(pass),
        .vec_cnt(vec_cnt), .err_cnt(err_cnt), .cov(cov),
        .first_fail(first_fail), .first_fail_vld(first_fail_vld)
    );

    gate_checker #(.NUM_VEC(255), .CNT_W(8)) dut255 (
        .clk(clk), .rst(rst), .start(start2), .abort(abort), .op(op),
        .in_valid(in_valid), .in_a(in_a), .in_b(in_b), .in_y(in_y),
        .in_ready(in_ready2), .busy(busy2), .done(done2), .pass(pass2),
        .vec_cnt(vec_cnt2), .err_cnt(err_cnt2), .cov(cov2),
        .first_fail(first_fail2), .first_fail_vld(first_fail_vld2)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic a, input logic b, input logic y);
        in_valid = 1'b1;
        in_a = a;
        in_b = b;
        in_y = y;
        step();
    endtask

    task automatic pulse_start(input logic [2:0] o);
        op = o;
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    initial begin
        // reset values
        step();
        check("rst_ready", in_ready, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_pass", pass, 0);
        check("rst_vec", vec_cnt, 0);
        check("rst_err", err_cnt, 0);
        check("rst_cov", cov, 0);
        check("rst_ff", {first_fail_vld, first_fail}, 0);
        rst = 1'b0;
        step();

        // correct AND gate
        pulse_start(3'd0);
        check("and_busy", busy, 1);
        check("and_ready", in_ready, 1);
        send(0, 0, 0); send(0, 1, 0); send(1, 0, 0); send(1, 1, 1);
        in_valid = 1'b0;
        check("and_done", done, 1);
        check("and_busy_low", busy, 0);
        check("and_vec", vec_cnt, 4);
        check("and_err", err_cnt, 0);
        check("and_cov", cov, 4'hF);
        check("and_pass", pass, 1);
        step();
        check("and_hold_pass", pass, 1);

        // faulty AND gate, restarted from DONE
        pulse_start(3'd0);
        check("fault_restart_vec", vec_cnt, 0);
        send(0, 0, 0); send(0, 1, 1); send(1, 0, 0); send(1, 1, 1);
        in_valid = 1'b0;
`ifdef GATE_CHECKER_FAIL_LOG_EN
        exp_ff = 3'b011; exp_ff_vld = 1'b1;
`else
        exp_ff = 3'b000; exp_ff_vld = 1'b0;
`endif
        check("fault_done", done, 1);
        check("fault_err", err_cnt, 1);
        check("fault_pass", pass, 0);
        check("fault_ff", first_fail, exp_ff);
        check("fault_ff_vld", first_fail_vld, exp_ff_vld);

        // XOR with incomplete coverage
        pulse_start(3'd2);
        send(0, 1, 1); send(0, 1, 1); send(0, 1, 1); send(0, 1, 1);
        in_valid = 1'b0;
        check("xor_done", done, 1);
        check("xor_err", err_cnt, 0);
        check("xor_cov", cov, 4'b0010);
        check("xor_pass", pass, 0);

        // OR run with op changed mid-run, then aborted
        pulse_start(3'd1);
        op = 3'd0;
        send(0, 1, 1); send(1, 0, 1);
        in_valid = 1'b0;
        check("opchg_err", err_cnt, 0);
        check("opchg_vec", vec_cnt, 2);
        abort = 1'b1;
        step();
        abort = 1'b0;
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_vec", vec_cnt, 0);
        check("abort_cov", cov, 0);

        // asynchronous reset mid-run
        pulse_start(3'd0);
        send(1, 1, 0);
        in_valid = 1'b0;
        check("pre_rst_vec", vec_cnt, 1);
        #2 rst = 1'b1;
        #1;
        check("async_busy", busy, 0);
        check("async_vec", vec_cnt, 0);
        check("async_err", err_cnt, 0);
        check("async_cov", cov, 0);
        check("async_ff_vld", first_fail_vld, 0);
        #1 rst = 1'b0;
        step();

        // in_valid in IDLE is ignored
        send(1, 1, 1); send(0, 0, 0); send(1, 0, 1);
        in_valid = 1'b0;
        check("idle_vec", vec_cnt, 0);
        check("idle_ready", in_ready, 0);

        // start and abort together
        op = 3'd0;
        start = 1'b1;
        abort = 1'b1;
        step();
        start = 1'b0;
        abort = 1'b0;
        check("startabort_busy", busy, 0);
        check("startabort_done", done, 0);

        // start during RUN ignored
        pulse_start(3'd0);
        send(0, 0, 0); send(0, 1, 0);
        in_valid = 1'b0;
        pulse_start(3'd1);
        check("run_start_vec", vec_cnt, 2);
        check("run_start_busy", busy, 1);
        send(1, 0, 0); send(1, 1, 1);
        in_valid = 1'b0;
        check("run_start_done", done, 1);
        check("run_start_pass", pass, 1);

        // reserved op
        pulse_start(3'd7);
        send(0, 0, 0); send(0, 1, 0); send(1, 0, 0); send(1, 1, 1);
        in_valid = 1'b0;
        check("rsv_done", done, 1);
        check("rsv_err", err_cnt, 4);
        check("rsv_pass", pass, 0);

        // NUM_VEC=255 with 300 mismatching XOR vectors
        op = 3'd2;
        start2 = 1'b1;
        step();
        start2 = 1'b0;
        check("sat_busy", busy2, 1);
        for (int i = 1; i <= 300; i++) begin
            send(0, 0, 1);
            if (i == 254) begin
                check("sat_done_254", done2, 0);
                check("sat_err_254", err_cnt2, 254);
            end
            if (i == 255) begin
                check("sat_done_255", done2, 1);
                check("sat_err_255", err_cnt2, 255);
                check("sat_vec_255", vec_cnt2, 255);
            end
        end
        in_valid = 1'b0;
        check("sat_err_300", err_cnt2, 255);
        check("sat_vec_300", vec_cnt2, 255);
        check("sat_done_300", done2, 1);
        check("sat_pass", pass2, 0);
        check("other_unchanged_err", err_cnt, 4);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
